// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a mem_ready stall/timeout.
// Define MIPS_LOGIC_IMM_EN to execute andi/ori through IEXEC with zero-extension.
module mips_multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       ext_zero,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                           S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                           S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8,
                           S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
                           S_TRAP   = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_SW  = 6'b101011,
                           OP_BEQ  = 6'b000100, OP_J    = 6'b000010, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;

    localparam int unsigned CW = $clog2(WAIT_MAX + 2);
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          bus_err_q, bus_err_d;
    logic          is_logic_imm;
    logic          waiting;
    logic          pc_write_c, pc_write_cond_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;

`ifdef MIPS_LOGIC_IMM_EN
    assign is_logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
`else
    assign is_logic_imm = 1'b0;
`endif

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_R)                          state_d = S_EXEC;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
                else if (opcode == OP_J)                     state_d = S_JUMP;
                else if (opcode == OP_ADDI || is_logic_imm)  state_d = S_IEXEC;
                else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
        // The counter holds cycles already stalled; a ready in the limit cycle still completes.
        if (waiting && !mem_ready) begin
            if (WAIT_MAX != 0 && wait_q == WAIT_LAST) begin
                state_d   = S_TRAP;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        iord            = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_src          = 2'b00;
        ext_zero        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                mem_read_c = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_c = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_src          = 2'b01;
                pc_write_cond_c = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = is_logic_imm ? 2'b11 : 2'b00;
                ext_zero  = is_logic_imm;
            end
            S_IWB:   reg_write_c = 1'b1;
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held so no access or write leaks out.
    assign pc_write      = pc_write_c & rst_n;
    assign pc_write_cond = pc_write_cond_c & rst_n;
    assign mem_read      = mem_read_c & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign ir_write      = ir_write_c & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign illegal       = illegal_q;
    assign bus_err       = bus_err_q;
    assign state         = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: instruction walks, mem_ready stalls, timeout, reset.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, illegal, bus_err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .ext_zero(ext_zero), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        #3;
        chk("rst_state", state, 4'd0);
        chk("rst_illegal", {3'b0, illegal}, 4'd0);
        chk("rst_bus_err", {3'b0, bus_err}, 4'd0);
        chk("rst_mem_read", {3'b0, mem_read}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // lw: 0,1,2,3,4,0
        opcode = 6'b100011;
        chk("lw_fetch_ir_write", {3'b0, ir_write}, 4'd1);
        chk("lw_fetch_pc_write", {3'b0, pc_write}, 4'd1);
        chk("lw_fetch_alu_src_b", {2'b0, alu_src_b}, 4'd1);
        tick(); chk("lw_s1", state, 4'd1);
        chk("lw_dec_alu_src_b", {2'b0, alu_src_b}, 4'd3);
        tick(); chk("lw_s2", state, 4'd2);
        chk("lw_memadr_src", {1'b0, alu_src_a, alu_src_b}, 4'b0110);
        tick(); chk("lw_s3", state, 4'd3);
        chk("lw_memrd_iord_rd", {2'b0, iord, mem_read}, 4'b0011);
        chk("lw_memrd_reg_write", {3'b0, reg_write}, 4'd0);
        tick(); chk("lw_s4", state, 4'd4);
        chk("lw_memwb_wb", {2'b0, mem_to_reg, reg_write}, 4'b0011);
        tick(); chk("lw_back_fetch", state, 4'd0);

        // R-type: 0,1,6,7,0
        opcode = 6'b000000;
        tick(); chk("r_s1", state, 4'd1);
        tick(); chk("r_s6", state, 4'd6);
        chk("r_exec_alu_op", {2'b0, alu_op}, 4'd2);
        tick(); chk("r_s7", state, 4'd7);
        chk("r_aluwb", {2'b0, reg_dst, reg_write}, 4'b0011);
        tick(); chk("r_back_fetch", state, 4'd0);

        // beq: 0,1,8,0
        opcode = 6'b000100;
        tick(); tick(); chk("beq_s8", state, 4'd8);
        chk("beq_pc_write_cond", {3'b0, pc_write_cond}, 4'd1);
        chk("beq_pc_src", {2'b0, pc_src}, 4'd1);
        chk("beq_alu_op", {2'b0, alu_op}, 4'd1);
        chk("beq_pc_write", {3'b0, pc_write}, 4'd0);
        tick(); chk("beq_back_fetch", state, 4'd0);

        // j: 0,1,11,0
        opcode = 6'b000010;
        tick(); tick(); chk("j_s11", state, 4'd11);
        chk("j_pc", {1'b0, pc_write, pc_src}, 4'b0110);
        tick(); chk("j_back_fetch", state, 4'd0);

        // addi: 0,1,9,10,0
        opcode = 6'b001000;
        tick(); tick(); chk("addi_s9", state, 4'd9);
        chk("addi_iexec", {1'b0, ext_zero, alu_op}, 4'b0000);
        chk("addi_src_b", {2'b0, alu_src_b}, 4'd2);
        tick(); chk("addi_s10", state, 4'd10);
        chk("addi_iwb", {1'b0, reg_dst, mem_to_reg, reg_write}, 4'b0001);
        tick(); chk("addi_back_fetch", state, 4'd0);

        // sw with 3 stall cycles in MEMWR
        opcode = 6'b101011;
        tick(); tick(); tick(); chk("sw_s5", state, 4'd5);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("sw_stall_mem_write", {3'b0, mem_write}, 4'd1);
            tick(); chk("sw_stall_state", state, 4'd5);
        end
        mem_ready = 1'b1;
        tick(); chk("sw_done_fetch", state, 4'd0);

        // ready arrives in the very cycle the limit would be reached
        tick(); tick(); tick(); chk("sw2_s5", state, 4'd5);
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sw2_still_waiting", state, 4'd5);
        mem_ready = 1'b1;
        tick(); chk("sw2_ready_wins", state, 4'd0);
        chk("sw2_no_bus_err", {3'b0, bus_err}, 4'd0);

        // timeout after 15 low cycles
        tick(); tick(); tick(); chk("sw3_s5", state, 4'd5);
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sw3_before_limit", state, 4'd5);
        tick(); chk("sw3_trap", state, 4'd12);
        chk("sw3_flags", {2'b0, bus_err, illegal}, 4'b0010);
        chk("sw3_strobes", {mem_write, mem_read, reg_write, pc_write}, 4'b0000);
        mem_ready = 1'b1;
        tick(); chk("sw3_trap_sticky", state, 4'd12);

        // ori: feature-dependent
        do_reset();
        chk("ori_rst_bus_err", {3'b0, bus_err}, 4'd0);
        opcode = 6'b001101;
        tick(); tick();
`ifdef MIPS_LOGIC_IMM_EN
        chk("ori_s9", state, 4'd9);
        chk("ori_iexec", {1'b0, ext_zero, alu_op}, 4'b0111);
        tick(); chk("ori_s10", state, 4'd10);
        tick(); chk("ori_back_fetch", state, 4'd0);
`else
        chk("ori_trap", state, 4'd12);
        chk("ori_illegal", {2'b0, bus_err, illegal}, 4'b0001);
        chk("ori_ext_zero", {3'b0, ext_zero}, 4'd0);
`endif

        // undefined opcode traps with illegal
        do_reset();
        opcode = 6'b111111;
        tick(); tick(); chk("bad_op_trap", state, 4'd12);
        chk("bad_op_flags", {2'b0, bus_err, illegal}, 4'b0001);

        // reset while stalled in MEMRD
        do_reset();
        chk("post_rst_illegal", {3'b0, illegal}, 4'd0);
        opcode = 6'b100011;
        tick(); tick(); tick(); chk("rr_s3", state, 4'd3);
        mem_ready = 1'b0;
        tick(); chk("rr_stalled", state, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_state", state, 4'd0);
        chk("rr_strobes", {mem_write, mem_read, reg_write, ir_write}, 4'b0000);
        chk("rr_flags", {2'b0, bus_err, illegal}, 4'b0000);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rr_fetch_read", {3'b0, mem_read}, 4'd1);
        tick(); chk("rr_resume_decode", state, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
